// File: rtl/cache_control_if.sv
// rtl/cache_control_if.sv - CPU, datapath-status, array-control and pmem signals of the L1 cache controller.
interface cache_control_if;
  logic mem_read;
  logic mem_write;
  logic mem_resp;
  logic ishit_w1;
  logic ishit_w2;
  logic isdirty_w1;
  logic isdirty_w2;
  logic lru_out;
  logic load_lru;
  logic load_tag_w1;
  logic load_valid_w1;
  logic load_dirty_w1;
  logic load_datastore_w1;
  logic load_tag_w2;
  logic load_valid_w2;
  logic load_dirty_w2;
  logic load_datastore_w2;
  logic dirty_wdata;
  logic datastore_in_mux_sel;
  logic pmem_addr_sel;
  logic pmem_read;
  logic pmem_write;
  logic pmem_resp;

  modport slave (
    input  mem_read, mem_write, ishit_w1, ishit_w2, isdirty_w1, isdirty_w2,
           lru_out, pmem_resp,
    output mem_resp, load_lru, load_tag_w1, load_valid_w1, load_dirty_w1,
           load_datastore_w1, load_tag_w2, load_valid_w2, load_dirty_w2,
           load_datastore_w2, dirty_wdata, datastore_in_mux_sel, pmem_addr_sel,
           pmem_read, pmem_write
  );

  modport master (
    output mem_read, mem_write, ishit_w1, ishit_w2, isdirty_w1, isdirty_w2,
           lru_out, pmem_resp,
    input  mem_resp, load_lru, load_tag_w1, load_valid_w1, load_dirty_w1,
           load_datastore_w1, load_tag_w2, load_valid_w2, load_dirty_w2,
           load_datastore_w2, dirty_wdata, datastore_in_mux_sel, pmem_addr_sel,
           pmem_read, pmem_write
  );
endinterface

// File: rtl/cache_control.sv
// rtl/cache_control.sv - 2-way L1 cache sequencing FSM: hit service, dirty writeback, line fill.
// Optional saturating performance counters enabled by CACHE_PERF_CNT_EN.
module cache_control (
  input  logic        clk,
  input  logic        reset_n,
`ifdef CACHE_PERF_CNT_EN
  input  logic        perf_clr,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count,
  output logic [15:0] wb_count,
`endif
  cache_control_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WRITEBACK, FILL} state_t;

  state_t state;
  state_t next_state;
  logic   req;
  logic   hit;
  logic   hit_w2;
  logic   victim_dirty;
  logic   miss_go;
  logic   wb_go;

  assign req          = bus.mem_read | bus.mem_write;
  assign hit          = bus.ishit_w1 | bus.ishit_w2;
  assign hit_w2       = bus.ishit_w2 & ~bus.ishit_w1;
  assign victim_dirty = bus.lru_out ? bus.isdirty_w2 : bus.isdirty_w1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state                 = state;
    miss_go                    = 1'b0;
    wb_go                      = 1'b0;
    bus.mem_resp               = 1'b0;
    bus.load_lru               = 1'b0;
    bus.load_tag_w1            = 1'b0;
    bus.load_valid_w1          = 1'b0;
    bus.load_dirty_w1          = 1'b0;
    bus.load_datastore_w1      = 1'b0;
    bus.load_tag_w2            = 1'b0;
    bus.load_valid_w2          = 1'b0;
    bus.load_dirty_w2          = 1'b0;
    bus.load_datastore_w2      = 1'b0;
    bus.dirty_wdata            = 1'b0;
    bus.datastore_in_mux_sel   = 1'b0;
    bus.pmem_addr_sel          = 1'b0;
    bus.pmem_read              = 1'b0;
    bus.pmem_write             = 1'b0;
    // Outputs are forced low for the whole reset assertion, not just after the edge.
    if (reset_n) begin
      unique case (state)
        IDLE: begin
          if (req && hit) begin
            bus.mem_resp = 1'b1;
            bus.load_lru = (hit_w2 == bus.lru_out);
            if (bus.mem_write) begin
              bus.load_datastore_w1 = ~hit_w2;
              bus.load_dirty_w1     = ~hit_w2;
              bus.load_datastore_w2 = hit_w2;
              bus.load_dirty_w2     = hit_w2;
              bus.dirty_wdata       = 1'b1;
            end
          end else if (req) begin
            miss_go    = 1'b1;
            next_state = victim_dirty ? WRITEBACK : FILL;
          end
        end
        WRITEBACK: begin
          bus.pmem_write    = 1'b1;
          bus.pmem_addr_sel = 1'b1;
          if (bus.pmem_resp) begin
            wb_go      = 1'b1;
            next_state = FILL;
          end
        end
        FILL: begin
          bus.pmem_read = 1'b1;
          if (bus.pmem_resp) begin
            bus.load_tag_w1          = ~bus.lru_out;
            bus.load_valid_w1        = ~bus.lru_out;
            bus.load_dirty_w1        = ~bus.lru_out;
            bus.load_datastore_w1    = ~bus.lru_out;
            bus.load_tag_w2          = bus.lru_out;
            bus.load_valid_w2        = bus.lru_out;
            bus.load_dirty_w2        = bus.lru_out;
            bus.load_datastore_w2    = bus.lru_out;
            bus.datastore_in_mux_sel = 1'b1;
            next_state               = IDLE;
          end
        end
        default: next_state = IDLE;
      endcase
    end
  end

`ifdef CACHE_PERF_CNT_EN
  logic miss_pending;

  // Every IDLE cycle ends any earlier miss; a withdrawn request must not suppress later hits.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)           miss_pending <= 1'b0;
    else if (state == IDLE) miss_pending <= miss_go;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hit_count  <= 16'd0;
      miss_count <= 16'd0;
      wb_count   <= 16'd0;
    end else if (perf_clr) begin
      hit_count  <= 16'd0;
      miss_count <= 16'd0;
      wb_count   <= 16'd0;
    end else begin
      if (bus.mem_resp && !miss_pending && hit_count != 16'hFFFF)
        hit_count <= hit_count + 16'd1;
      if (miss_go && miss_count != 16'hFFFF)
        miss_count <= miss_count + 16'd1;
      if (wb_go && wb_count != 16'hFFFF)
        wb_count <= wb_count + 16'd1;
    end
  end
`else
  // Counter-free build: the FSM above is the whole controller.
`endif

endmodule

// File: tb/tb_cache_control.sv
// tb/tb_cache_control.sv - scoreboard bench for cache_control with directed per-cycle vectors.
module tb_cache_control;
  logic        clk;
  logic        reset_n;
  logic        perf_clr;
  logic [15:0] hit_count;
  logic [15:0] miss_count;
  logic [15:0] wb_count;

  cache_control_if bus ();

  cache_control dut (
    .clk        (clk),
    .reset_n    (reset_n),
`ifdef CACHE_PERF_CNT_EN
    .perf_clr   (perf_clr),
    .hit_count  (hit_count),
    .miss_count (miss_count),
    .wb_count   (wb_count),
`endif
    .bus        (bus)
  );

`ifndef CACHE_PERF_CNT_EN
  assign hit_count  = 16'd0;
  assign miss_count = 16'd0;
  assign wb_count   = 16'd0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [14:0] O_RESP = 15'h4000;
  localparam logic [14:0] O_LRU  = 15'h2000;
  localparam logic [14:0] O_TAG1 = 15'h1000;
  localparam logic [14:0] O_VAL1 = 15'h0800;
  localparam logic [14:0] O_DIR1 = 15'h0400;
  localparam logic [14:0] O_DS1  = 15'h0200;
  localparam logic [14:0] O_TAG2 = 15'h0100;
  localparam logic [14:0] O_VAL2 = 15'h0080;
  localparam logic [14:0] O_DIR2 = 15'h0040;
  localparam logic [14:0] O_DS2  = 15'h0020;
  localparam logic [14:0] O_DWD  = 15'h0010;
  localparam logic [14:0] O_MUX  = 15'h0008;
  localparam logic [14:0] O_ASEL = 15'h0004;
  localparam logic [14:0] O_PRD  = 15'h0002;
  localparam logic [14:0] O_PWR  = 15'h0001;
  localparam logic [14:0] FILL1  = O_TAG1 | O_VAL1 | O_DIR1 | O_DS1 | O_MUX | O_PRD;
  localparam logic [14:0] FILL2  = O_TAG2 | O_VAL2 | O_DIR2 | O_DS2 | O_MUX | O_PRD;
  localparam logic [14:0] WB     = O_PWR | O_ASEL;

  typedef struct {
    logic [14:0] exp;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passes = 0;

  function automatic logic [14:0] outs();
    return {bus.mem_resp, bus.load_lru, bus.load_tag_w1, bus.load_valid_w1,
            bus.load_dirty_w1, bus.load_datastore_w1, bus.load_tag_w2,
            bus.load_valid_w2, bus.load_dirty_w2, bus.load_datastore_w2,
            bus.dirty_wdata, bus.datastore_in_mux_sel, bus.pmem_addr_sel,
            bus.pmem_read, bus.pmem_write};
  endfunction

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got 0x%04h expected 0x%04h", name, got, exp);
  endtask

  // Monitor: compares the DUT outputs on the falling edge whenever a vector is outstanding.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check(e.name, {1'b0, outs()}, {1'b0, e.exp});
    end
  end

  task automatic step(input bit rst, input bit rd, input bit wr, input bit h1, input bit h2,
                      input bit d1, input bit d2, input bit lru, input bit presp,
                      input logic [14:0] exp, input string name);
    exp_t e;
    @(posedge clk);
    #1;
    reset_n        = rst;
    bus.mem_read   = rd;
    bus.mem_write  = wr;
    bus.ishit_w1   = h1;
    bus.ishit_w2   = h2;
    bus.isdirty_w1 = d1;
    bus.isdirty_w2 = d2;
    bus.lru_out    = lru;
    bus.pmem_resp  = presp;
    e.exp  = exp;
    e.name = name;
    exp_q.push_back(e);
  endtask

  initial begin
    reset_n  = 1'b0;
    perf_clr = 1'b0;
    bus.mem_read = 0; bus.mem_write = 0; bus.ishit_w1 = 0; bus.ishit_w2 = 0;
    bus.isdirty_w1 = 0; bus.isdirty_w2 = 0; bus.lru_out = 0; bus.pmem_resp = 0;

    // rst rd wr h1 h2 d1 d2 lru presp
    step(0, 1, 0, 1, 0, 0, 0, 0, 0, 15'h0, "reset_outputs_low");
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 15'h0, "idle_no_req");
    step(1, 1, 0, 0, 1, 0, 0, 1, 0, O_RESP | O_LRU, "read_hit_w2");
    step(1, 0, 1, 1, 0, 0, 0, 1, 0, O_RESP | O_DS1 | O_DIR1 | O_DWD, "write_hit_w1");
    step(1, 1, 0, 1, 1, 0, 0, 0, 0, O_RESP | O_LRU, "both_hit_w1_wins");
    step(1, 1, 1, 0, 1, 0, 0, 0, 0, O_RESP | O_DS2 | O_DIR2 | O_DWD, "rdwr_is_write_w2");

    // Clean read miss into way 1, pmem answers on the third FILL cycle.
    step(1, 1, 0, 0, 0, 0, 0, 0, 0, 15'h0, "clean_miss_idle");
    step(1, 1, 0, 0, 0, 0, 0, 0, 0, O_PRD, "clean_fill_c2");
    step(1, 1, 0, 0, 0, 0, 0, 0, 0, O_PRD, "clean_fill_c3");
    step(1, 1, 0, 0, 0, 0, 0, 0, 1, FILL1, "clean_fill_load_w1");
    step(1, 1, 0, 1, 0, 0, 0, 0, 0, O_RESP | O_LRU, "clean_miss_resp_c5");

    perf_clr = 1'b1;
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 15'h0, "idle_clear");
    @(posedge clk);
    #1;
    perf_clr = 1'b0;

    // Dirty write miss on way 2: two-cycle writeback then two-cycle fill.
    step(1, 0, 1, 0, 0, 0, 1, 1, 0, 15'h0, "dirty_miss_idle");
    step(1, 0, 1, 0, 0, 0, 1, 1, 0, WB, "wb_c2");
    step(1, 0, 1, 0, 0, 0, 1, 1, 1, WB, "wb_resp_c3");
    step(1, 0, 1, 0, 0, 0, 1, 1, 0, O_PRD, "fill_no_gap_c4");
    step(1, 0, 1, 0, 0, 0, 1, 1, 1, FILL2, "fill_load_w2_c5");
    step(1, 0, 1, 0, 1, 0, 1, 1, 0, O_RESP | O_LRU | O_DS2 | O_DIR2 | O_DWD, "dirty_resp_merge_c6");
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 15'h0, "idle_after_dirty");
`ifdef CACHE_PERF_CNT_EN
    check("miss_count_dirty", miss_count, 16'd1);
    check("wb_count_dirty", wb_count, 16'd1);
    check("hit_count_dirty", hit_count, 16'd0);
`endif

    // Request withdrawn during the fill: line still installed, no response.
    step(1, 1, 0, 0, 0, 0, 0, 0, 0, 15'h0, "withdraw_miss");
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, O_PRD, "withdraw_fill");
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, FILL1, "withdraw_fill_load");
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 15'h0, "withdraw_no_resp");

    // Reset in the middle of a writeback.
    step(1, 0, 1, 0, 0, 1, 0, 0, 0, 15'h0, "rst_miss_idle");
    step(1, 0, 1, 0, 0, 1, 0, 0, 0, WB, "rst_wb_c2");
    step(0, 0, 1, 0, 0, 1, 0, 0, 0, 15'h0, "rst_wb_drops");
`ifdef CACHE_PERF_CNT_EN
    check("miss_count_reset", miss_count, 16'd0);
    check("wb_count_reset", wb_count, 16'd0);
    check("hit_count_reset", hit_count, 16'd0);
`endif
    step(1, 1, 0, 1, 0, 0, 0, 1, 0, O_RESP, "post_reset_idle_hit");
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 15'h0, "post_reset_idle");

`ifdef CACHE_PERF_CNT_EN
    @(posedge clk);
    #1;
    perf_clr = 1'b1;
    bus.mem_read = 1; bus.ishit_w1 = 1; bus.lru_out = 1;
    @(posedge clk);
    #1;
    check("clr_wins_over_hit", hit_count, 16'd0);
    perf_clr = 1'b0;
    repeat (65535) @(posedge clk);
    #1;
    check("hit_count_full", hit_count, 16'hFFFF);
    @(posedge clk);
    #1;
    check("hit_count_saturates", hit_count, 16'hFFFF);
    perf_clr = 1'b1;
    @(posedge clk);
    #1;
    check("hit_count_cleared", hit_count, 16'd0);
    perf_clr = 1'b0;
    bus.mem_read = 0; bus.ishit_w1 = 0;
`endif

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() == 0) passes++;
    else $display("FAIL scoreboard_drain: %0d vectors left, expected 0", exp_q.size());
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
